// File: rtl/dpram_pkg.sv
// Shared types and constants for the parametrised dual-port RAM.
package dpram_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } dpram_state_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/dpram_init_seq.sv
// Post-reset clear sequencer: sweeps every address once, then raises ready.
module dpram_init_seq
    import dpram_pkg::*;
#(
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready_o,
    output logic              init_we_o,
    output logic [ADDR_W-1:0] init_addr_o
);

    dpram_state_t      state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    ptr_q <= ptr_q + ADDR_W'(1);
                    if (ptr_q == '1) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                ST_READY: ;
                default: begin
                    state_q <= ST_INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o     = ready_q;
    assign init_we_o   = (state_q == ST_INIT);
    assign init_addr_o = ptr_q;

endmodule

// File: rtl/dual_port_ram_param.sv
// True dual-port synchronous RAM with clear sweep, collision arbitration and counter.
// Define DPRAM_BYPASS_EN for write-first forwarding on write-read collisions.
module dual_port_ram_param
    import dpram_pkg::*;
#(
    parameter int unsigned          DATA_W   = 4,
    parameter int unsigned          ADDR_W   = 2,
    parameter bit                   PRIO_A   = 1'b1,
    parameter logic [DATA_W-1:0]    INIT_VAL = '0,
    parameter int unsigned          CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_A,
    input  logic              en_B,
    input  logic              R_W_A,
    input  logic              R_W_B,
    input  logic [ADDR_W-1:0] address_A,
    input  logic [ADDR_W-1:0] address_B,
    input  logic [DATA_W-1:0] data_in_A,
    input  logic [DATA_W-1:0] data_in_B,
    output logic [DATA_W-1:0] data_out_A,
    output logic [DATA_W-1:0] data_out_B,
    output logic              valid_A,
    output logic              valid_B,
    output logic              ready,
    output logic              collision,
    output logic [CNT_W-1:0]  collision_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              ready_w;
    logic              init_we;
    logic [ADDR_W-1:0] init_addr;

    logic              same_addr, wr_A, wr_B, rd_A, rd_B, ww_coll, we_A, we_B;
    logic              coll_d;
    logic [DATA_W-1:0] rdata_A_d, rdata_B_d;
    logic [CNT_W-1:0]  cnt_d;

    logic [DATA_W-1:0] data_out_A_q, data_out_B_q;
    logic              valid_A_q, valid_B_q, collision_q;
    logic [CNT_W-1:0]  cnt_q;

    dpram_init_seq #(.ADDR_W(ADDR_W)) u_init (
        .clk         (clk),
        .rst         (rst),
        .ready_o     (ready_w),
        .init_we_o   (init_we),
        .init_addr_o (init_addr)
    );

    always_comb begin
        same_addr = (address_A == address_B);
        wr_A      = ready_w & en_A & (R_W_A == RW_WRITE);
        wr_B      = ready_w & en_B & (R_W_B == RW_WRITE);
        rd_A      = ready_w & en_A & (R_W_A == RW_READ);
        rd_B      = ready_w & en_B & (R_W_B == RW_READ);
        ww_coll   = wr_A & wr_B & same_addr;
        // the losing port's write is suppressed so only one write hits the word
        we_A      = wr_A & ~(ww_coll & ~PRIO_A);
        we_B      = wr_B & ~(ww_coll & PRIO_A);
        coll_d    = ready_w & en_A & en_B & same_addr & (wr_A | wr_B);

        rdata_A_d = mem_q[address_A];
        rdata_B_d = mem_q[address_B];
`ifdef DPRAM_BYPASS_EN
        if (we_B && same_addr) rdata_A_d = data_in_B;
        if (we_A && same_addr) rdata_B_d = data_in_A;
`endif

        cnt_d = cnt_q;
        if (coll_d && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (init_we) begin
            mem_q[init_addr] <= INIT_VAL;
        end else begin
            if (we_A) mem_q[address_A] <= data_in_A;
            if (we_B) mem_q[address_B] <= data_in_B;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_A_q <= '0;
            data_out_B_q <= '0;
            valid_A_q    <= 1'b0;
            valid_B_q    <= 1'b0;
            collision_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            if (rd_A) data_out_A_q <= rdata_A_d;
            if (rd_B) data_out_B_q <= rdata_B_d;
            valid_A_q   <= rd_A;
            valid_B_q   <= rd_B;
            collision_q <= coll_d;
            cnt_q       <= cnt_d;
        end
    end

    assign data_out_A      = data_out_A_q;
    assign data_out_B      = data_out_B_q;
    assign valid_A         = valid_A_q;
    assign valid_B         = valid_B_q;
    assign ready           = ready_w;
    assign collision       = collision_q;
    assign collision_count = cnt_q;

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Scoreboard bench: default DUT, a PRIO_A=0 variant and a CNT_W=2 variant share one stimulus stream.
module tb_dual_port_ram_param;
    import dpram_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en_A = 1'b0, en_B = 1'b0, R_W_A = 1'b0, R_W_B = 1'b0;
    logic [1:0] address_A = '0, address_B = '0;
    logic [3:0] data_in_A = '0, data_in_B = '0;

    logic [3:0] doA [3];
    logic [3:0] doB [3];
    logic       vA [3];
    logic       vB [3];
    logic       rdy [3];
    logic       col [3];
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;

    int total = 0;
    int bad   = 0;
    int n;
    int qA0[$], qA1[$], qA2[$], qB0[$], qB1[$], qB2[$];

    always #5 clk = ~clk;

    dual_port_ram_param u0 (
        .clk(clk), .rst(rst), .en_A(en_A), .en_B(en_B), .R_W_A(R_W_A), .R_W_B(R_W_B),
        .address_A(address_A), .address_B(address_B), .data_in_A(data_in_A), .data_in_B(data_in_B),
        .data_out_A(doA[0]), .data_out_B(doB[0]), .valid_A(vA[0]), .valid_B(vB[0]),
        .ready(rdy[0]), .collision(col[0]), .collision_count(cnt0));

    dual_port_ram_param #(.PRIO_A(1'b0)) u1 (
        .clk(clk), .rst(rst), .en_A(en_A), .en_B(en_B), .R_W_A(R_W_A), .R_W_B(R_W_B),
        .address_A(address_A), .address_B(address_B), .data_in_A(data_in_A), .data_in_B(data_in_B),
        .data_out_A(doA[1]), .data_out_B(doB[1]), .valid_A(vA[1]), .valid_B(vB[1]),
        .ready(rdy[1]), .collision(col[1]), .collision_count(cnt1));

    dual_port_ram_param #(.CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .en_A(en_A), .en_B(en_B), .R_W_A(R_W_A), .R_W_B(R_W_B),
        .address_A(address_A), .address_B(address_B), .data_in_A(data_in_A), .data_in_B(data_in_B),
        .data_out_A(doA[2]), .data_out_B(doB[2]), .valid_A(vA[2]), .valid_B(vB[2]),
        .ready(rdy[2]), .collision(col[2]), .collision_count(cnt2));

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic miss(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got valid pulse expected none queued", nm);
    endtask

    // port 0 = A, 1 = B; one expected read value per DUT instance
    task automatic expect_rd(input bit port, input int e0, input int e1, input int e2);
        if (port == 1'b0) begin
            qA0.push_back(e0); qA1.push_back(e1); qA2.push_back(e2);
        end else begin
            qB0.push_back(e0); qB1.push_back(e1); qB2.push_back(e2);
        end
    endtask

    task automatic req(input logic ea, input logic rwa, input logic [1:0] aa, input logic [3:0] da,
                       input logic eb, input logic rwb, input logic [1:0] ab, input logic [3:0] db);
        en_A = ea; R_W_A = rwa; address_A = aa; data_in_A = da;
        en_B = eb; R_W_B = rwb; address_B = ab; data_in_B = db;
        @(posedge clk); #1;
        en_A = 1'b0; en_B = 1'b0;
    endtask

    always @(negedge clk) begin
        if (vA[0]) begin if (qA0.size() == 0) miss("rdA0"); else chk("rdA0", int'(doA[0]), qA0.pop_front()); end
        if (vA[1]) begin if (qA1.size() == 0) miss("rdA1"); else chk("rdA1", int'(doA[1]), qA1.pop_front()); end
        if (vA[2]) begin if (qA2.size() == 0) miss("rdA2"); else chk("rdA2", int'(doA[2]), qA2.pop_front()); end
        if (vB[0]) begin if (qB0.size() == 0) miss("rdB0"); else chk("rdB0", int'(doB[0]), qB0.pop_front()); end
        if (vB[1]) begin if (qB1.size() == 0) miss("rdB1"); else chk("rdB1", int'(doB[1]), qB1.pop_front()); end
        if (vB[2]) begin if (qB2.size() == 0) miss("rdB2"); else chk("rdB2", int'(doB[2]), qB2.pop_front()); end
    end

    task automatic wait_ready(input string nm);
        n = 0;
        while (!rdy[0] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, n, 4);
    endtask

    task automatic chk_reset_state(input string nm);
        for (int i = 0; i < 3; i++) begin
            chk({nm, "_doA"}, int'(doA[i]), 0);
            chk({nm, "_doB"}, int'(doB[i]), 0);
            chk({nm, "_vA"}, int'(vA[i]), 0);
            chk({nm, "_vB"}, int'(vB[i]), 0);
            chk({nm, "_rdy"}, int'(rdy[i]), 0);
            chk({nm, "_col"}, int'(col[i]), 0);
        end
        chk({nm, "_cnt0"}, int'(cnt0), 0);
        chk({nm, "_cnt1"}, int'(cnt1), 0);
        chk({nm, "_cnt2"}, int'(cnt2), 0);
    endtask

    initial begin
        int bypass_exp;
`ifdef DPRAM_BYPASS_EN
        bypass_exp = 7;
`else
        bypass_exp = 3;
`endif
        // reset state and clear sweep
        #1 rst = 1'b1;
        #2 chk_reset_state("reset");
        #9 rst = 1'b0;
        wait_ready("ready_edges");
        for (int a = 0; a < 4; a++) begin
            expect_rd(1'b0, 0, 0, 0);
            req(1'b1, RW_READ, 2'(a), 4'd0, 1'b0, RW_READ, 2'd0, 4'd0);
        end

        // A writes, B reads back, no collisions
        for (int a = 0; a < 4; a++) begin
            req(1'b1, RW_WRITE, 2'(a), 4'(3 * (a + 1)), 1'b0, RW_READ, 2'd0, 4'd0);
            chk("coll_wr", int'(col[0]), 0);
        end
        for (int a = 0; a < 4; a++) begin
            expect_rd(1'b1, 3 * (a + 1), 3 * (a + 1), 3 * (a + 1));
            req(1'b0, RW_READ, 2'd0, 4'd0, 1'b1, RW_READ, 2'(a), 4'd0);
            chk("coll_rd", int'(col[0]), 0);
        end
        chk("cnt_none", int'(cnt0), 0);

        // write-write collision at address 0
        req(1'b1, RW_WRITE, 2'd0, 4'd4, 1'b1, RW_WRITE, 2'd0, 4'd11);
        chk("coll_ww", int'(col[0]), 1);
        chk("cnt_ww0", int'(cnt0), 1);
        chk("cnt_ww1", int'(cnt1), 1);
        expect_rd(1'b1, 4, 11, 4);
        req(1'b0, RW_READ, 2'd0, 4'd0, 1'b1, RW_READ, 2'd0, 4'd0);
        chk("coll_once", int'(col[0]), 0);

        // write-read collision at address 1
        req(1'b1, RW_WRITE, 2'd1, 4'd3, 1'b0, RW_READ, 2'd0, 4'd0);
        expect_rd(1'b1, bypass_exp, bypass_exp, bypass_exp);
        req(1'b1, RW_WRITE, 2'd1, 4'd7, 1'b1, RW_READ, 2'd1, 4'd0);
        chk("coll_wr_rd", int'(col[0]), 1);
        expect_rd(1'b0, 7, 7, 7);
        req(1'b1, RW_READ, 2'd1, 4'd0, 1'b0, RW_READ, 2'd0, 4'd0);
        chk("cnt_wr_rd", int'(cnt0), 2);
        chk("cnt_wr_rd2", int'(cnt2), 2);

        // five more collisions: narrow counter saturates
        for (int k = 0; k < 5; k++) begin
            expect_rd(1'b1, 12, 12, 12);
            req(1'b1, RW_WRITE, 2'd3, 4'd12, 1'b1, RW_READ, 2'd3, 4'd0);
        end
        chk("cnt_sat2", int'(cnt2), 3);
        chk("cnt_wide0", int'(cnt0), 7);
        chk("cnt_wide1", int'(cnt1), 7);

        // reset while ready with address 2 holding 8
        req(1'b1, RW_WRITE, 2'd2, 4'd8, 1'b0, RW_READ, 2'd0, 4'd0);
        expect_rd(1'b0, 8, 8, 8);
        req(1'b1, RW_READ, 2'd2, 4'd0, 1'b0, RW_READ, 2'd0, 4'd0);
        @(posedge clk); #1;
        chk("hold_doA", int'(doA[0]), 8);
        chk("hold_vA", int'(vA[0]), 0);
        #2 rst = 1'b1;
        #1 chk_reset_state("midrst");
        @(posedge clk); @(posedge clk); #7 rst = 1'b0;
        wait_ready("ready_edges2");
        expect_rd(1'b0, 0, 0, 0);
        req(1'b1, RW_READ, 2'd2, 4'd0, 1'b0, RW_READ, 2'd0, 4'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("queues_drained", qA0.size() + qA1.size() + qA2.size() + qB0.size() + qB1.size() + qB2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dual_port_ram_param.md
# dual_port_ram_param

Parametrised true dual-port synchronous RAM, the successor to the fixed 4x4 dual-port RAM. It adds:
- configurable data width and depth,
- per-port enables and read-valid strobes,
- a hardware memory-clear sequence after reset,
- deterministic write-write collision resolution, with a saturating collision counter.

It sits between two independent masters sharing one storage array in the same clock domain.

## Interface
- DATA_W, 4, data width in bits
- ADDR_W, 2, address width; depth = 2**ADDR_W
- PRIO_A, 1, 1 = port A wins write-write collisions, 0 = port B wins
- INIT_VAL, 0, value written to every word during the clear sequence
- CNT_W, 8, collision counter width
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- en_A / en_B  in  1  port request enable
- R_W_A / R_W_B  in  1  1 = write, 0 = read (meaningful only while the matching en is high)
- address_A / address_B  in  ADDR_W  word address
- data_in_A / data_in_B  in  DATA_W  write data
- data_out_A / data_out_B  out  DATA_W  registered read data
- valid_A / valid_B  out  1  one-cycle pulse: data_out updated by an accepted read
- ready  out  1  high when the clear sequence is done and requests are accepted
- collision  out  1  one-cycle pulse: a collision was detected on the previous edge
- collision_count  out  CNT_W  saturating count of collisions since reset

## Operation
- FSM states are ST_INIT and ST_READY. Reset forces ST_INIT with the sweep pointer at 0.
- ST_INIT:
  - Each edge writes INIT_VAL to mem[ptr] and increments ptr.
  - After writing word 2**ADDR_W-1, go to ST_READY.
  - Port requests are ignored: no writes, and valid stays 0.
- ST_READY:
  - A port with en=1, R_W=1 writes mem[address] <= data_in.
  - A port with en=1, R_W=0 reads mem[address] into data_out and pulses valid.
- Collision: both en high, addresses equal, and at least one port writing.
  - Write-write: only the priority port's data is stored; the other write is dropped.
  - Write-read: the write always lands. What the reading port returns is set under Configuration.
  - Read-read: not a collision; both ports return the same word.
- On every collision in ST_READY:
  - collision pulses on the next cycle.
  - collision_count increments, saturating at all-ones.
- Reset values: data_out_A/B = 0, valid_A/B = 0, ready = 0, collision = 0, collision_count = 0.
- data_out holds its last value when no read is accepted.
- Reset asserted mid-operation or mid-sweep: all outputs return to reset values immediately. The sweep restarts at address 0 after release. Memory content is undefined until the sweep rewrites it.

## Timing
- Read latency is 1 cycle: request sampled on edge N; data_out/valid valid after edge N and held until edge N+1.
- A write is visible to a read sampled on the following edge.
- ready rises after the 2**ADDR_W-th rising edge following rst release: 4 edges at ADDR_W=2.
- collision and valid are aligned: both are registered on the same edge that samples the request.

## Configuration
- DPRAM_BYPASS_EN defined: on a write-read collision, the reading port returns the newly written data (write-first forwarding).
- DPRAM_BYPASS_EN undefined: on a write-read collision, the reading port returns the old stored data (read-first).
- The collision pulse and counter behave identically in both builds.

## Structure
- Package dpram_pkg holds:
  - state enum dpram_state_t {ST_INIT, ST_READY},
  - the R_W encoding constants (RW_READ = 0, RW_WRITE = 1).
- Sub-module dpram_init_seq holds the clear FSM and sweep pointer, driving ready, the init write enable and the init address. The top level muxes it ahead of the port write logic.

## Test plan
Default parameters throughout.
1. Reset release: count edges until ready = 1 -> exactly 4. Then read addresses 0..3 on port A -> all return 0, one valid pulse each.
2. Port A writes 3, 6, 9, 12 to addresses 0..3, then port B reads 0..3 -> 3, 6, 9, 12, each 1 cycle after its request. collision stays 0.
3. Same cycle: A writes 4 to address 0 and B writes 11 to address 0, PRIO_A = 1 -> address 0 reads 4. collision pulses once and collision_count = 1. Rerun with PRIO_A = 0 -> address 0 reads 11.
4. Address 1 holds 3. A writes 7 to address 1 while B reads address 1 -> data_out_B = 3 without DPRAM_BYPASS_EN, 7 with it. A subsequent read returns 7 in both builds.
5. With CNT_W = 2, force 5 collisions -> collision_count saturates at 3.
6. Assert rst while ready = 1 with address 2 holding 8 -> outputs reset immediately. After release, ready returns after 4 edges and address 2 reads 0.
